proc_mem_arb: RTL and testbench
===============================

Name: proc_mem_arb

Overview:
Two-requester arbiter that shares one single-ported memory between the processor's instruction-fetch port (imem, requester 0) and data port (dmem, requester 1).
- Grants at most one request per cycle to the memory using val/rdy handshakes.
- Tracks the owner of each in-flight request in an ID FIFO, and steers in-order memory responses back to the owner.
- Sits between the processor's imem/dmem ports and the unified memory.

Parameters:
MAX_INFLIGHT, 4, ID FIFO depth (max outstanding memory requests), power of two, >=2
ADDR_W, 32, address width
DATA_W, 32, data width

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
imem_req_val  input  1  fetch request valid
imem_req_rdy  output  1  fetch request accepted this cycle
imem_req_addr  input  ADDR_W  fetch address (fetch is always a read)
imem_resp_val  output  1  fetch response valid
imem_resp_data  output  DATA_W  fetch response data
dmem_req_val  input  1  data request valid
dmem_req_rdy  output  1  data request accepted this cycle
dmem_req_type  input  1  0=read, 1=write
dmem_req_addr  input  ADDR_W  data address
dmem_req_wdata  input  DATA_W  store data
dmem_resp_val  output  1  data response valid (reads and writes)
dmem_resp_data  output  DATA_W  load data; don't-care for writes
mem_req_val  output  1  request to memory valid
mem_req_rdy  input  1  memory accepts request
mem_req_type  output  1  0=read, 1=write
mem_req_addr  output  ADDR_W  address
mem_req_wdata  output  DATA_W  write data
mem_resp_val  input  1  memory response valid; in order, one per request, never back-pressured
mem_resp_data  input  DATA_W  response data

Behaviour:
- Handshake completes when val & rdy are both high in the same cycle. The request path is combinational: there is zero added latency from req to mem_req.
- can_issue = ~fifo_full | (mem_resp_val & ~fifo_empty). A dequeue in the same cycle frees a slot.
- Grant:
  - Computed only when can_issue and ~rst.
  - If only one requester is valid, grant it.
  - If both are valid, grant the requester holding priority (see Optional Feature).
- mem_req_val = granted requester's val. mem_req_* fields are muxed from the granted requester; imem supplies type=0 and wdata=0.
- X_req_rdy = grant_X & mem_req_rdy & can_issue. The non-granted requester's rdy is 0.
- On a memory handshake, push the requester ID (0/1) into the ID FIFO.
- On mem_resp_val:
  - Pop the FIFO head.
  - Assert resp_val of the head ID the same cycle; the other resp_val stays 0.
  - Both resp_data outputs carry mem_resp_data.
- mem_resp_val with the FIFO empty: ignored. No resp_val is asserted and the FIFO is not modified.
- Simultaneous push and pop: both take effect; occupancy is unchanged.
- Full FIFO with no same-cycle response: both rdy = 0 and mem_req_val = 0.
- FIFO pointers wrap modulo MAX_INFLIGHT. Occupancy counter is log2(MAX_INFLIGHT)+1 bits.
- While rst is high:
  - mem_req_val, imem_req_rdy, dmem_req_rdy, imem_resp_val and dmem_resp_val are all 0.
  - Next edge: FIFO empty, pointers 0, priority = dmem.
- Reset mid-operation discards all in-flight IDs. Responses arriving after reset for pre-reset requests are dropped by the empty rule above.

Optional Feature:
Macro PROC_MEM_ARB_RR_EN.
- Defined: round-robin. A priority register (reset = dmem) flips to the other requester after every completed memory handshake. Only a completed handshake updates it; a stalled grant does not.
- Undefined: fixed priority; dmem always wins a tie. No priority register exists.

Decomposition:
Shared package/header holds:
- MEM_REQ_READ=0 and MEM_REQ_WRITE=1.
- Requester IDs ARB_ID_IMEM=0 and ARB_ID_DMEM=1.
- A mem request struct typedef {type, addr, wdata}.

One natural sub-module: arb_id_fifo, a parameterized 1-bit-wide synchronous FIFO. It has push, pop, full, empty and head, and supports same-cycle push+pop.

Test Plan:
1. Reset, then imem_req_val=1 addr=0x200, mem_req_rdy=1, one-cycle mem latency -> mem_req_addr=0x200 same cycle. Next cycle mem_resp_data=0xDEADBEEF gives imem_resp_val=1 and dmem_resp_val=0.
2. Both valid, dmem write addr=0x1000 wdata=0x5, mem_req_rdy=1 -> dmem granted first (type=1). With RR_EN, imem granted the next cycle. Without RR_EN, dmem wins while it stays valid.
3. mem_req_rdy=0 for 3 cycles with both valid -> no rdy asserted, FIFO unchanged, priority register unchanged.
4. Issue 4 requests (MAX_INFLIGHT=4) with no responses -> rdy=0 on the 5th. Assert mem_resp_val in the same cycle as the 5th -> it is accepted, occupancy stays 4, and the popped ID is routed correctly.
5. Interleaved IDs imem, dmem, dmem, imem, then 4 responses 0x1..0x4 -> resp_val sequence imem, dmem, dmem, imem with matching data.
6. Assert rst with 2 in flight, then deliver 2 stale responses -> both resp_val stay 0. A new imem request then completes normally.

Source files
------------

// File: rtl/proc_mem_arb_pkg.sv
// Shared constants and types for the imem/dmem-to-memory arbiter.
package proc_mem_arb_pkg;

    // Widths the request struct is built with; the arbiter's ADDR_W/DATA_W
    // parameters default to these and must not exceed them.
    localparam int ARB_ADDR_W = 32;
    localparam int ARB_DATA_W = 32;

    // Memory request type encoding.
    localparam logic MEM_REQ_READ  = 1'b0;
    localparam logic MEM_REQ_WRITE = 1'b1;

    // Requester IDs stored in the ID FIFO.
    localparam logic ARB_ID_IMEM = 1'b0;
    localparam logic ARB_ID_DMEM = 1'b1;

    typedef struct packed {
        logic                  req_type;
        logic [ARB_ADDR_W-1:0] addr;
        logic [ARB_DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/proc_mem_arb_if.sv
// Bundle of the imem, dmem and unified-memory ports around the arbiter.
// Handshake rule for every req channel: a transfer happens in the cycle where
// val and rdy are both high; val may not wait on rdy. Responses have no rdy:
// resp_val is a single-cycle pulse the receiver must take.
interface proc_mem_arb_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              imem_req_val;
    logic              imem_req_rdy;
    logic [ADDR_W-1:0] imem_req_addr;
    logic              imem_resp_val;
    logic [DATA_W-1:0] imem_resp_data;

    logic              dmem_req_val;
    logic              dmem_req_rdy;
    logic              dmem_req_type;
    logic [ADDR_W-1:0] dmem_req_addr;
    logic [DATA_W-1:0] dmem_req_wdata;
    logic              dmem_resp_val;
    logic [DATA_W-1:0] dmem_resp_data;

    logic              mem_req_val;
    logic              mem_req_rdy;
    logic              mem_req_type;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [DATA_W-1:0] mem_req_wdata;
    logic              mem_resp_val;
    logic [DATA_W-1:0] mem_resp_data;

    // Arbiter view.
    modport slave (
        input  imem_req_val, imem_req_addr,
        output imem_req_rdy, imem_resp_val, imem_resp_data,
        input  dmem_req_val, dmem_req_type, dmem_req_addr, dmem_req_wdata,
        output dmem_req_rdy, dmem_resp_val, dmem_resp_data,
        output mem_req_val, mem_req_type, mem_req_addr, mem_req_wdata,
        input  mem_req_rdy, mem_resp_val, mem_resp_data
    );

    // Processor and memory view.
    modport master (
        output imem_req_val, imem_req_addr,
        input  imem_req_rdy, imem_resp_val, imem_resp_data,
        output dmem_req_val, dmem_req_type, dmem_req_addr, dmem_req_wdata,
        input  dmem_req_rdy, dmem_resp_val, dmem_resp_data,
        input  mem_req_val, mem_req_type, mem_req_addr, mem_req_wdata,
        output mem_req_rdy, mem_resp_val, mem_resp_data
    );
endinterface

// File: rtl/proc_mem_arb_id_fifo.sv
// 1-bit-wide synchronous FIFO holding the owner ID of each in-flight memory
// request. Push and pop may happen in the same cycle, including when full.
module proc_mem_arb_id_fifo #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_push,
    input  logic i_pop,
    input  logic i_din,
    output logic o_full,
    output logic o_empty,
    output logic o_head
);
    localparam int PTR_W = $clog2(DEPTH);

    logic             r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == (PTR_W+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop & ~o_empty;
    // A pop in the same cycle frees the slot the push lands in.
    assign w_do_push = i_push & (~o_full | w_do_pop);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_din;
    end
endmodule

// File: rtl/proc_mem_arb.sv
// Arbiter sharing one single-ported memory between instruction fetch (imem,
// ID 0) and data (dmem, ID 1). Request path is combinational; response owners
// are tracked in an ID FIFO and responses return in order.
// Optional: define PROC_MEM_ARB_RR_EN for round-robin priority; otherwise
// dmem wins every tie.
module proc_mem_arb
    import proc_mem_arb_pkg::*;
#(
    parameter int MAX_INFLIGHT = 4,
    parameter int ADDR_W       = ARB_ADDR_W,
    parameter int DATA_W       = ARB_DATA_W
) (
    input  logic                 clk,
    input  logic                 rst,
    proc_mem_arb_if.slave        bus
);
    logic     w_full;
    logic     w_empty;
    logic     w_head;
    logic     w_can_issue;
    logic     w_prio_dmem;
    logic     w_grant_imem;
    logic     w_grant_dmem;
    logic     w_mem_req_val;
    logic     w_mem_hs;
    logic     w_pop;
    logic     w_push_id;
    mem_req_t w_imem_req;
    mem_req_t w_dmem_req;
    mem_req_t w_sel_req;

    // A response this cycle frees a FIFO slot for a new request this cycle.
    assign w_can_issue = ~w_full | (bus.mem_resp_val & ~w_empty);

`ifdef PROC_MEM_ARB_RR_EN
    logic r_prio_dmem;

    // Priority flips on every completed memory handshake, never on a stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prio_dmem <= 1'b1;
        end else if (w_mem_hs) begin
            r_prio_dmem <= ~r_prio_dmem;
        end
    end

    assign w_prio_dmem = r_prio_dmem;
`else
    assign w_prio_dmem = 1'b1;
`endif

    // Grant at most one valid requester, only when a FIFO slot is available.
    always_comb begin
        w_grant_imem = 1'b0;
        w_grant_dmem = 1'b0;
        if (!rst && w_can_issue) begin
            if (bus.dmem_req_val && (!bus.imem_req_val || w_prio_dmem)) begin
                w_grant_dmem = 1'b1;
            end else if (bus.imem_req_val) begin
                w_grant_imem = 1'b1;
            end
        end
    end

    // Build both candidate requests and steer the granted one to memory.
    always_comb begin
        w_imem_req.req_type = MEM_REQ_READ;
        w_imem_req.addr     = ARB_ADDR_W'(bus.imem_req_addr);
        w_imem_req.wdata    = '0;
        w_dmem_req.req_type = bus.dmem_req_type;
        w_dmem_req.addr     = ARB_ADDR_W'(bus.dmem_req_addr);
        w_dmem_req.wdata    = ARB_DATA_W'(bus.dmem_req_wdata);
        w_sel_req           = w_grant_dmem ? w_dmem_req : w_imem_req;
    end

    // A grant implies the granted requester is valid.
    assign w_mem_req_val     = w_grant_imem | w_grant_dmem;
    assign w_mem_hs          = w_mem_req_val & bus.mem_req_rdy;
    assign w_push_id         = w_grant_dmem ? ARB_ID_DMEM : ARB_ID_IMEM;

    assign bus.mem_req_val   = w_mem_req_val;
    assign bus.mem_req_type  = w_sel_req.req_type;
    assign bus.mem_req_addr  = ADDR_W'(w_sel_req.addr);
    assign bus.mem_req_wdata = DATA_W'(w_sel_req.wdata);

    assign bus.imem_req_rdy  = w_grant_imem & bus.mem_req_rdy;
    assign bus.dmem_req_rdy  = w_grant_dmem & bus.mem_req_rdy;

    // Responses with nothing outstanding (e.g. stale after reset) are dropped.
    assign w_pop              = bus.mem_resp_val & ~w_empty & ~rst;
    assign bus.imem_resp_val  = w_pop & (w_head == ARB_ID_IMEM);
    assign bus.dmem_resp_val  = w_pop & (w_head == ARB_ID_DMEM);
    assign bus.imem_resp_data = bus.mem_resp_data;
    assign bus.dmem_resp_data = bus.mem_resp_data;

    proc_mem_arb_id_fifo #(
        .DEPTH (MAX_INFLIGHT)
    ) u_id_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_mem_hs),
        .i_pop   (w_pop),
        .i_din   (w_push_id),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head)
    );
endmodule

// File: tb/tb_proc_mem_arb.sv
// Directed, table-driven bench for proc_mem_arb plus a hand-written
// tie-break sequence checked against a small priority/ID model.
module tb_proc_mem_arb;
    import proc_mem_arb_pkg::*;

`ifdef PROC_MEM_ARB_RR_EN
    localparam logic RR = 1'b1;
`else
    localparam logic RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    proc_mem_arb_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    proc_mem_arb #(
        .MAX_INFLIGHT (4),
        .ADDR_W       (32),
        .DATA_W       (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        rst;
        logic        iv;
        logic [31:0] ia;
        logic        dv;
        logic        dt;
        logic [31:0] da;
        logic [31:0] dw;
        logic        mr;
        logic        rv;
        logic [31:0] rd;
        logic        e_ir;
        logic        e_dr;
        logic        e_mv;
        logic        e_mt;
        logic [31:0] e_ma;
        logic [31:0] e_mw;
        logic        e_irv;
        logic        e_drv;
    } vec_t;

    vec_t        vecs[$];
    logic [0:0]  exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic iv, input logic [31:0] ia,
                         input logic dv, input logic dt, input logic [31:0] da,
                         input logic [31:0] dw, input logic mr, input logic rv,
                         input logic [31:0] rd);
        rst                = r;
        bus.imem_req_val   = iv;
        bus.imem_req_addr  = ia;
        bus.dmem_req_val   = dv;
        bus.dmem_req_type  = dt;
        bus.dmem_req_addr  = da;
        bus.dmem_req_wdata = dw;
        bus.mem_req_rdy    = mr;
        bus.mem_resp_val   = rv;
        bus.mem_resp_data  = rd;
    endtask

    task automatic add(input logic r, input logic iv, input logic [31:0] ia,
                       input logic dv, input logic dt, input logic [31:0] da,
                       input logic [31:0] dw, input logic mr, input logic rv,
                       input logic [31:0] rd, input logic e_ir, input logic e_dr,
                       input logic e_mv, input logic e_mt, input logic [31:0] e_ma,
                       input logic [31:0] e_mw, input logic e_irv, input logic e_drv);
        vec_t v;
        v.rst = r;  v.iv = iv; v.ia = ia; v.dv = dv; v.dt = dt; v.da = da; v.dw = dw;
        v.mr = mr;  v.rv = rv; v.rd = rd;
        v.e_ir = e_ir; v.e_dr = e_dr; v.e_mv = e_mv; v.e_mt = e_mt;
        v.e_ma = e_ma; v.e_mw = e_mw; v.e_irv = e_irv; v.e_drv = e_drv;
        vecs.push_back(v);
    endtask

    // Hard stop in case the main sequence never finishes.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic prio_d;
        logic id;

        drive(1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // rst iv ia        dv dt da        dw    mr rv rd            ir    dr    mv mt    ma                          mw                    irv   drv
        add(1, 1, 'h200,    1, 1, 'h1000,   'h5,  1, 1, 'h77,         0,    0,    0, 0,    0,                          0,                    0,    0);   // reset masks all
        add(1, 0, 0,        0, 0, 0,        0,    1, 0, 0,            0,    0,    0, 0,    0,                          0,                    0,    0);
        add(0, 1, 'h200,    0, 0, 0,        0,    1, 0, 0,            1,    0,    1, 0,    'h200,                      0,                    0,    0);   // fetch issues same cycle
        add(0, 0, 0,        0, 0, 0,        0,    1, 1, 'hDEADBEEF,   0,    0,    0, 0,    0,                          0,                    1,    0);   // routed to imem
        add(1, 0, 0,        0, 0, 0,        0,    1, 0, 0,            0,    0,    0, 0,    0,                          0,                    0,    0);
        add(0, 1, 'h300,    1, 1, 'h1000,   'h5,  1, 0, 0,            0,    1,    1, 1,    'h1000,                     'h5,                  0,    0);   // tie: dmem first
        add(0, 1, 'h300,    1, 1, 'h1000,   'h5,  1, 0, 0,            RR,   !RR,  1, !RR,  RR ? 32'h300 : 32'h1000,    RR ? 32'h0 : 32'h5,   0,    0);
        for (int k = 0; k < 3; k++)
            add(0, 1, 'h300, 1, 1, 'h1000,  'h5,  0, 0, 0,            0,    0,    1, 1,    'h1000,                     'h5,                  0,    0);   // stall
        add(0, 1, 'h300,    1, 1, 'h1000,   'h5,  1, 0, 0,            0,    1,    1, 1,    'h1000,                     'h5,                  0,    0);   // prio unchanged by stall
        add(0, 0, 0,        0, 0, 0,        0,    1, 1, 'h11,         0,    0,    0, 0,    0,                          0,                    0,    1);
        add(0, 0, 0,        0, 0, 0,        0,    1, 1, 'h22,         0,    0,    0, 0,    0,                          0,                    RR,   !RR);
        add(0, 0, 0,        0, 0, 0,        0,    1, 1, 'h33,         0,    0,    0, 0,    0,                          0,                    0,    1);
        add(1, 0, 0,        0, 0, 0,        0,    1, 0, 0,            0,    0,    0, 0,    0,                          0,                    0,    0);
        add(0, 1, 'h100,    0, 0, 0,        0,    1, 0, 0,            1,    0,    1, 0,    'h100,                      0,                    0,    0);   // I
        add(0, 0, 0,        1, 0, 'h104,    0,    1, 0, 0,            0,    1,    1, 0,    'h104,                      0,                    0,    0);   // D read
        add(0, 0, 0,        1, 1, 'h108,    'hAA, 1, 0, 0,            0,    1,    1, 1,    'h108,                      'hAA,                 0,    0);   // D write
        add(0, 1, 'h10C,    0, 0, 0,        0,    1, 0, 0,            1,    0,    1, 0,    'h10C,                      0,                    0,    0);   // I, now full
        add(0, 1, 'h110,    0, 0, 0,        0,    1, 0, 0,            0,    0,    0, 0,    0,                          0,                    0,    0);   // full blocks
        add(0, 1, 'h110,    0, 0, 0,        0,    1, 1, 'h1,          1,    0,    1, 0,    'h110,                      0,                    1,    0);   // push+pop when full
        add(0, 1, 'h114,    0, 0, 0,        0,    1, 0, 0,            0,    0,    0, 0,    0,                          0,                    0,    0);   // still full
        add(0, 0, 0,        0, 0, 0,        0,    1, 1, 'h2,          0,    0,    0, 0,    0,                          0,                    0,    1);
        add(0, 0, 0,        0, 0, 0,        0,    1, 1, 'h3,          0,    0,    0, 0,    0,                          0,                    0,    1);
        add(0, 0, 0,        0, 0, 0,        0,    1, 1, 'h4,          0,    0,    0, 0,    0,                          0,                    1,    0);
        add(0, 0, 0,        0, 0, 0,        0,    1, 1, 'h5,          0,    0,    0, 0,    0,                          0,                    1,    0);
        add(0, 0, 0,        0, 0, 0,        0,    1, 1, 'h6,          0,    0,    0, 0,    0,                          0,                    0,    0);   // empty: ignored
        add(0, 1, 'h200,    0, 0, 0,        0,    1, 0, 0,            1,    0,    1, 0,    'h200,                      0,                    0,    0);
        add(0, 0, 0,        1, 0, 'h204,    0,    1, 0, 0,            0,    1,    1, 0,    'h204,                      0,                    0,    0);
        add(1, 0, 0,        0, 0, 0,        0,    1, 0, 0,            0,    0,    0, 0,    0,                          0,                    0,    0);   // reset, 2 in flight
        add(0, 0, 0,        0, 0, 0,        0,    1, 1, 'h7,          0,    0,    0, 0,    0,                          0,                    0,    0);   // stale
        add(0, 0, 0,        0, 0, 0,        0,    1, 1, 'h8,          0,    0,    0, 0,    0,                          0,                    0,    0);   // stale
        add(0, 1, 'h300,    0, 0, 0,        0,    1, 0, 0,            1,    0,    1, 0,    'h300,                      0,                    0,    0);
        add(0, 0, 0,        0, 0, 0,        0,    1, 1, 'h9,          0,    0,    0, 0,    0,                          0,                    1,    0);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].iv, vecs[i].ia, vecs[i].dv, vecs[i].dt,
                  vecs[i].da, vecs[i].dw, vecs[i].mr, vecs[i].rv, vecs[i].rd);
            #1;
            check($sformatf("ctl[%0d] {irdy,drdy,mval,irv,drv}", i),
                  {bus.imem_req_rdy, bus.dmem_req_rdy, bus.mem_req_val,
                   bus.imem_resp_val, bus.dmem_resp_val},
                  {vecs[i].e_ir, vecs[i].e_dr, vecs[i].e_mv, vecs[i].e_irv, vecs[i].e_drv});
            if (vecs[i].e_mv)
                check($sformatf("mreq[%0d] {type,addr,wdata}", i),
                      {bus.mem_req_type, bus.mem_req_addr, bus.mem_req_wdata},
                      {vecs[i].e_mt, vecs[i].e_ma, vecs[i].e_mw});
            if (vecs[i].e_irv || vecs[i].e_drv)
                check($sformatf("rdata[%0d] {imem,dmem}", i),
                      {bus.imem_resp_data, bus.dmem_resp_data},
                      {vecs[i].rd, vecs[i].rd});
        end

        // Both requesters held valid: grant order follows the priority model,
        // then the fifth tie is blocked by the full ID FIFO.
        @(negedge clk);
        drive(1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        prio_d = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive(1'b0, 1, 32'h500 + 32'(k), 1, 0, 32'h600 + 32'(k), 0, 1, 0, 0);
            #1;
            id = prio_d;
            check($sformatf("tie_grant[%0d] {irdy,drdy,mval}", k),
                  {bus.imem_req_rdy, bus.dmem_req_rdy, bus.mem_req_val}, {~id, id, 1'b1});
            check($sformatf("tie_addr[%0d]", k), bus.mem_req_addr,
                  id ? 32'h600 + 32'(k) : 32'h500 + 32'(k));
            exp_q.push_back(id);
            if (RR) prio_d = ~prio_d;
        end
        @(negedge clk);
        drive(1'b0, 1, 32'h504, 1, 0, 32'h604, 0, 1, 0, 0);
        #1;
        check("tie_full {irdy,drdy,mval}",
              {bus.imem_req_rdy, bus.dmem_req_rdy, bus.mem_req_val}, 3'b000);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive(1'b0, 0, 0, 0, 0, 0, 0, 1, 1, 32'hA0 + 32'(k));
            #1;
            id = exp_q.pop_front();
            check($sformatf("tie_resp[%0d] {irv,drv,data}", k),
                  {bus.imem_resp_val, bus.dmem_resp_val, bus.imem_resp_data},
                  {~id, id, 32'hA0 + 32'(k)});
        end
        @(negedge clk);
        drive(1'b0, 0, 0, 0, 0, 0, 0, 1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
